// File: rtl/biquad_bank.sv
// Bank of NUM_BANDS direct-form-I biquads time-sharing one multiply-accumulator.
// Bands run in cascade or as a parallel sum, with a fixed-latency bypass.
module biquad_bank #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 18,
  parameter int FRAC_BITS = 16,
  parameter int NUM_BANDS = 3,
  parameter int ACC_W     = 40,
  localparam int BAND_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              ready,
  input  logic              coef_we,
  input  logic [BAND_W-1:0] coef_band,
  input  logic [2:0]        coef_sel,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              mode,
  input  logic              bypass,
  input  logic              state_clr,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic              overflow
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = DATA_W + $clog2(NUM_BANDS) + 1;

  localparam logic [COEF_W-1:0] UNITY =
    {{(COEF_W-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] S_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] S_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [BAND_W:0]   NB_LIM    = (BAND_W+1)'(NUM_BANDS);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS-1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

  state_t                    r_state;
  logic [2:0]                r_tap;
  logic [BAND_W-1:0]         r_band;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_xin;
  logic signed [DATA_W-1:0]  r_bin;
  logic signed [SUM_W-1:0]   r_sum;
  logic                      r_mode;
  logic                      r_bypass;
  logic                      r_clr_pend;
  logic [DATA_W-1:0]         r_sample_out;
  logic                      r_out_valid;
  logic                      r_overflow;

  logic signed [COEF_W-1:0]  r_shd [NUM_BANDS][5];
  logic signed [COEF_W-1:0]  r_act [NUM_BANDS][5];
  logic signed [DATA_W-1:0]  r_x1  [NUM_BANDS];
  logic signed [DATA_W-1:0]  r_x2  [NUM_BANDS];
  logic signed [DATA_W-1:0]  r_y1  [NUM_BANDS];
  logic signed [DATA_W-1:0]  r_y2  [NUM_BANDS];

  logic signed [DATA_W-1:0]  w_data;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_shift;
  logic                      w_y_ovf;
  logic signed [DATA_W-1:0]  w_y;
  logic                      w_sum_ovf;
  logic signed [DATA_W-1:0]  w_sum_sat;
  logic                      w_clr;
  logic                      w_coef_ok;

  assign ready      = (r_state == S_IDLE);
  assign sample_out = r_sample_out;
  assign out_valid  = r_out_valid;
  assign overflow   = r_overflow;

  // Tap order b0*x, b1*x1, b2*x2, a1*y1, a2*y2; feedback taps subtract.
  always_comb begin
    w_data = r_bin;
    case (r_tap)
      3'd1:    w_data = r_x1[r_band];
      3'd2:    w_data = r_x2[r_band];
      3'd3:    w_data = r_y1[r_band];
      3'd4:    w_data = r_y2[r_band];
      default: w_data = r_bin;
    endcase
    w_coef = r_act[r_band][0];
    case (r_tap)
      3'd1:    w_coef = r_act[r_band][1];
      3'd2:    w_coef = r_act[r_band][2];
      3'd3:    w_coef = r_act[r_band][3];
      3'd4:    w_coef = r_act[r_band][4];
      default: w_coef = r_act[r_band][0];
    endcase
    w_prod     = w_coef * w_data;
    w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    if (r_tap == 3'd0)      w_acc_next = w_prod_ext;
    else if (r_tap >= 3'd3) w_acc_next = r_acc - w_prod_ext;
    else                    w_acc_next = r_acc + w_prod_ext;
  end

  always_comb begin
    w_rnd   = r_acc + RND_HALF;
    w_shift = w_rnd >>> FRAC_BITS;
    w_y_ovf = (w_shift > Y_MAX) || (w_shift < Y_MIN);
    if (!w_y_ovf)            w_y = w_shift[DATA_W-1:0];
    else if (w_shift[ACC_W-1]) w_y = Y_MIN[DATA_W-1:0];
    else                     w_y = Y_MAX[DATA_W-1:0];
    w_sum_ovf = (r_sum > S_MAX) || (r_sum < S_MIN);
    if (!w_sum_ovf)          w_sum_sat = r_sum[DATA_W-1:0];
    else if (r_sum[SUM_W-1]) w_sum_sat = S_MIN[DATA_W-1:0];
    else                     w_sum_sat = S_MAX[DATA_W-1:0];
  end

  assign w_clr     = r_clr_pend | state_clr;
  assign w_coef_ok = coef_we && (coef_sel < 3'd5) && ({1'b0, coef_band} < NB_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_band       <= '0;
      r_acc        <= '0;
      r_xin        <= '0;
      r_bin        <= '0;
      r_sum        <= '0;
      r_mode       <= 1'b0;
      r_bypass     <= 1'b0;
      r_clr_pend   <= 1'b0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_x1[b] <= '0;
        r_x2[b] <= '0;
        r_y1[b] <= '0;
        r_y2[b] <= '0;
        for (int c = 0; c < 5; c++) begin
          r_shd[b][c] <= (c == 0) ? UNITY : '0;
          r_act[b][c] <= (c == 0) ? UNITY : '0;
        end
      end
    end else begin
      r_out_valid <= 1'b0;
      if (state_clr) r_clr_pend <= 1'b1;
      // Shadow write after the accept-edge copy: NBA ordering gives the copy the old value.
      if (w_coef_ok) r_shd[coef_band][coef_sel] <= coef_data;
      case (r_state)
        S_IDLE: begin
          if (sample_valid) begin
            r_xin      <= sample_in;
            r_bin      <= sample_in;
            r_mode     <= mode;
            r_bypass   <= bypass;
            r_sum      <= '0;
            r_band     <= '0;
            r_tap      <= '0;
            r_clr_pend <= 1'b0;
            r_state    <= S_MAC;
            for (int b = 0; b < NUM_BANDS; b++) begin
              for (int c = 0; c < 5; c++) r_act[b][c] <= r_shd[b][c];
              if (w_clr) begin
                r_x1[b] <= '0;
                r_x2[b] <= '0;
                r_y1[b] <= '0;
                r_y2[b] <= '0;
              end
            end
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_tap == 3'd4) r_state <= S_WB;
          else               r_tap   <= r_tap + 3'd1;
        end
        S_WB: begin
          if (!r_bypass) begin
            r_x2[r_band] <= r_x1[r_band];
            r_x1[r_band] <= r_bin;
            r_y2[r_band] <= r_y1[r_band];
            r_y1[r_band] <= w_y;
            r_sum        <= r_sum + {{(SUM_W-DATA_W){w_y[DATA_W-1]}}, w_y};
            if (!r_mode) r_bin <= w_y;
            if (w_y_ovf) r_overflow <= 1'b1;
          end
          r_tap <= '0;
          if (r_band == LAST_BAND) begin
            r_state <= S_OUT;
          end else begin
            r_band  <= r_band + 1'b1;
            r_state <= S_MAC;
          end
        end
        S_OUT: begin
          if (r_bypass)    r_sample_out <= r_xin;
          else if (r_mode) r_sample_out <= w_sum_sat;
          else             r_sample_out <= r_bin;
          if (!r_bypass && r_mode && w_sum_ovf) r_overflow <= 1'b1;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_bank.sv
// Self-checking bench for biquad_bank: driver tasks feed samples and coefficients,
// a monitor pops the expected queue on every out_valid and checks value and latency.
module tb_biquad_bank;

  localparam int DATA_W  = 16;
  localparam int COEF_W  = 18;
  localparam int LATENCY = 19;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              ready;
  logic              coef_we;
  logic [1:0]        coef_band;
  logic [2:0]        coef_sel;
  logic [COEF_W-1:0] coef_data;
  logic              mode;
  logic              bypass;
  logic              state_clr;
  logic [DATA_W-1:0] sample_out;
  logic              out_valid;
  logic              overflow;

  logic [DATA_W-1:0] exp_q[$];
  int                lat_q[$];
  int                n_total;
  int                n_bad;
  int                n_out;
  int                cyc;

  biquad_bank dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ready        (ready),
    .coef_we      (coef_we),
    .coef_band    (coef_band),
    .coef_sel     (coef_sel),
    .coef_data    (coef_data),
    .mode         (mode),
    .bypass       (bypass),
    .state_clr    (state_clr),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .overflow     (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && out_valid) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        logic [DATA_W-1:0] e;
        int a;
        e = exp_q.pop_front();
        a = lat_q.pop_front();
        check("sample_out", $signed(sample_out), $signed(e));
        check("latency", cyc - a, LATENCY);
      end
    end
  end

  // driver tasks
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic send_sample(input int val, input int exp);
    bit ok;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] e;
    wait_ready(ok);
    if (ok) begin
      v = val[DATA_W-1:0];
      e = exp[DATA_W-1:0];
      sample_in    = v;
      sample_valid = 1'b1;
      exp_q.push_back(e);
      lat_q.push_back(cyc + 1);
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  task automatic write_coef(input int band, input int sel, input int val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_band = band[1:0];
    coef_sel  = sel[2:0];
    coef_data = val[COEF_W-1:0];
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    state_clr = 1'b1;
    @(negedge clk);
    state_clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int v;
    int snap;
    n_total = 0;
    n_bad = 0;
    n_out = 0;
    reset = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    coef_band = '0;
    coef_sel = '0;
    coef_data = '0;
    mode = 1'b0;
    bypass = 1'b0;
    state_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_sample_out", sample_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ready", ready, 1);

    // defaults pass through, then output holds
    send_sample(16384, 16384);
    check("ready_busy", ready, 0);
    wait_drain();
    repeat (5) @(negedge clk);
    check("hold_out", $signed(sample_out), 16384);

    // half gain on band 0 in cascade, then all bands halved in parallel
    write_coef(0, 0, 32768);
    send_sample(1000, 500);
    wait_drain();
    write_coef(1, 0, 32768);
    write_coef(2, 0, 32768);
    mode = 1'b1;
    send_sample(1000, 1500);
    wait_drain();

    // first-order recursion y = x + 0.5*y1 with round-half-up
    mode = 1'b0;
    write_coef(0, 0, 65536);
    write_coef(1, 0, 65536);
    write_coef(2, 0, 65536);
    write_coef(0, 3, -32768);
    pulse_clr();
    send_sample(1000, 1000);
    send_sample(0, 500);
    send_sample(0, 250);
    send_sample(0, 125);
    send_sample(0, 63);
    wait_drain();

    // parallel sum saturation and sticky overflow
    write_coef(0, 3, 0);
    mode = 1'b1;
    pulse_clr();
    send_sample(20000, 32767);
    wait_drain();
    check("ovf_set", overflow, 1);
    send_sample(100, 300);
    wait_drain();
    check("ovf_sticky", overflow, 1);

    // coefficient write, clear and stray valid while busy
    mode = 1'b0;
    write_coef(0, 3, -32768);
    pulse_clr();
    send_sample(1000, 1000);
    wait_drain();
    snap = n_out;
    send_sample(200, 700);
    write_coef(0, 0, 32768);
    write_coef(3, 0, 12345);
    write_coef(0, 5, 12345);
    pulse_clr();
    @(negedge clk);
    sample_in = 16'h3039;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_drain();
    repeat (25) @(negedge clk);
    check("stray_valid_outs", n_out - snap, 1);
    send_sample(1000, 500);
    wait_drain();

    // bypass with random samples, histories must survive
    bypass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = int'($urandom_range(60000)) - 30000;
      send_sample(v, v);
    end
    wait_drain();
    bypass = 1'b0;
    send_sample(0, 250);
    wait_drain();

    // reset in the middle of a sample
    begin
      bit ok;
      wait_ready(ok);
      if (ok) begin
        sample_in = 16'd1000;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        snap = n_out;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_ready", ready, 1);
        check("rst2_overflow", overflow, 0);
        repeat (30) @(negedge clk);
        check("rst2_no_out", n_out - snap, 0);
      end
    end
    send_sample(1000, 1000);
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
